mul_arbiter: RTL and testbench
==============================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width of the shared multiplier.
REQ-002 Parameter MUL_LATENCY, default 1, cycles from multiplier capturing mul_in1/mul_in2 to product valid on mul_out; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0_valid / req1_valid  input  1  requester N presents an operand pair.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  WIDTH  requester N operands.
REQ-007 req0_ready / req1_ready  output  1  block accepts requester N's operands this cycle.
REQ-008 rsp0_valid / rsp1_valid  output  1  result for requester N held on rspN_data.
REQ-009 rsp0_data / rsp1_data  output  WIDTH  product returned to requester N.
REQ-010 rsp0_ready / rsp1_ready  input  1  requester N takes its result.
REQ-011 mul_in1, mul_in2  output  WIDTH  operands driven to the shared multiplier.
REQ-012 mul_out  input  WIDTH  shared multiplier product, low WIDTH bits of mul_in1*mul_in2.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, WAIT, RESP; one operation in flight at a time.
REQ-015 In IDLE, grant SHALL go to the only valid requester; when both are valid, to the requester not granted last (round-robin pointer).
REQ-016 reqN_ready SHALL be high only in IDLE, only for the granted N, and only while reqN_valid is high; the other ready SHALL be low.
REQ-017 Accept = reqN_valid & reqN_ready at a posedge; it SHALL register the operands onto mul_in1/mul_in2, record owner N, update the pointer to N, load the latency counter with MUL_LATENCY, and enter WAIT.
REQ-018 mul_in1/mul_in2 SHALL stay stable from accept until the next accept.
REQ-019 In WAIT the counter SHALL decrement each cycle; mul_out SHALL be sampled at the edge MUL_LATENCY+1 cycles after the accept edge, captured into rsp data for the owner, and state SHALL go to RESP.
REQ-020 With MUL_LATENCY=1, rspN_valid SHALL first be high in the third cycle after the accept cycle.
REQ-021 In RESP only the owner's rspN_valid SHALL be high; the other rsp valid SHALL be low.
REQ-022 rspN_data SHALL remain stable while rspN_valid is high and rspN_ready is low.
REQ-023 On rspN_valid & rspN_ready the FSM SHALL return to IDLE; the next accept SHALL occur no earlier than the following cycle.
REQ-024 rspN_ready SHALL be ignored outside RESP or for the non-owner.
REQ-025 Result SHALL be the low WIDTH bits of the product; overflow bits are dropped with no flag.
REQ-026 Request valid changes during WAIT/RESP SHALL have no effect on the in-flight operation.
REQ-027 Peak throughput SHALL be one operation per MUL_LATENCY+3 cycles.

Reset
REQ-028 While rst is high: state IDLE, busy 0, rsp0_valid/rsp1_valid 0, rsp0_data/rsp1_data 0, mul_in1/mul_in2 0, counter 0, pointer set so req0 wins the first tie.
REQ-029 Assertion of rst in WAIT or RESP SHALL abort the operation immediately; its result SHALL never be delivered after reset release.
REQ-030 First accept SHALL be possible in the first cycle after rst deasserts.

Verification
REQ-031 After reset, req0 valid with a=3, b=5, rsp0_ready=1 -> accept in cycle 0, rsp0_valid with rsp0_data=15 in cycle 3, rsp1_valid stays 0.
REQ-032 After reset, req0 (2,7) and req1 (4,4) both valid in the same cycle -> req0 served first (14), then req1 (16); req1_ready low until IDLE returns.
REQ-033 Both requesters held valid continuously for 6 operations -> grants alternate 0,1,0,1,0,1.
REQ-034 req1 a=300, b=300 -> rsp1_data=24464 (90000 mod 65536).
REQ-035 Result pending on rsp1 with rsp1_ready low for 5 cycles -> rsp1_valid and rsp1_data stable, busy=1, both req ready low; handshake on cycle 6 returns FSM to IDLE.
REQ-036 rst pulsed during WAIT of req0 (9,9) -> rsp0_valid never rises for that operation, all outputs 0, next request completes normally.

Source files
------------

// File: rtl/mul_arbiter.sv
// mul_arbiter: two requesters share one external pipelined multiplier.
// One operation is in flight at a time. Ties between the requesters are
// broken round-robin. The product is held for the owning requester until
// that requester takes it.
`timescale 1ns/1ps
module mul_arbiter #(
  parameter int WIDTH       = 16,
  parameter int MUL_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_data,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_data,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] mul_in1,
  output logic [WIDTH-1:0] mul_in2,
  input  logic [WIDTH-1:0] mul_out,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT = 4'(MUL_LATENCY);

  state_t           state_reg, state_next;
  logic             owner_reg;      // requester that owns the in-flight op
  logic             last_reg;       // requester granted most recently
  logic [3:0]       count_reg;
  logic [WIDTH-1:0] mul_in1_reg, mul_in2_reg;
  logic [WIDTH-1:0] rsp_data_reg [2];

  logic grant;
  logic accept;
  logic capture;
  logic rsp_taken;

  // Grant selection: lone requester wins; a tie goes to the one not served last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_reg;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state_reg == IDLE) && !grant && req0_valid;
  assign req1_ready = (state_reg == IDLE) &&  grant && req1_valid;
  assign accept     = req0_ready | req1_ready;

  // The product is ready once the counter has drained in WAIT.
  assign capture    = (state_reg == WAIT) && (count_reg == 4'd0);
  assign rsp_taken  = owner_reg ? rsp1_ready : rsp0_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)    state_next = WAIT;
      WAIT:    if (capture)   state_next = RESP;
      RESP:    if (rsp_taken) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand launch, ownership, round-robin pointer and latency counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_in1_reg <= '0;
      mul_in2_reg <= '0;
      owner_reg   <= 1'b0;
      last_reg    <= 1'b1;   // so req0 wins the first tie
      count_reg   <= 4'd0;
    end else if (accept) begin
      mul_in1_reg <= grant ? req1_a : req0_a;
      mul_in2_reg <= grant ? req1_b : req0_b;
      owner_reg   <= grant;
      last_reg    <= grant;
      count_reg   <= LAT;
    end else if ((state_reg == WAIT) && (count_reg != 4'd0)) begin
      count_reg   <= count_reg - 4'd1;
    end
  end

  // Per-requester result registers; only the owner's copy is overwritten.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rsp_data_reg[gi] <= '0;
        end else if (capture && (owner_reg == 1'(gi))) begin
          rsp_data_reg[gi] <= mul_out;
        end
      end
    end
  endgenerate

  assign rsp0_valid = (state_reg == RESP) && !owner_reg;
  assign rsp1_valid = (state_reg == RESP) &&  owner_reg;
  assign rsp0_data  = rsp_data_reg[0];
  assign rsp1_data  = rsp_data_reg[1];
  assign mul_in1    = mul_in1_reg;
  assign mul_in2    = mul_in2_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed testbench for mul_arbiter with a one-stage registered multiplier.
`timescale 1ns/1ps
module tb_mul_arbiter;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic             req0_ready, req1_ready;
  logic             rsp0_valid, rsp1_valid;
  logic [WIDTH-1:0] rsp0_data, rsp1_data;
  logic             rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [WIDTH-1:0] mul_in1, mul_in2;
  logic [WIDTH-1:0] mul_out = '0;
  logic             busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle_cnt    = 0;

  mul_arbiter #(.WIDTH(WIDTH), .MUL_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
    .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_out(mul_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // External multiplier: one register stage, low WIDTH bits of the product.
  always @(posedge clk) begin
    mul_out <= mul_in1 * mul_in2;
    cycle_cnt <= cycle_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    tick();
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    tests_run++;
    if ({rsp0_valid, rsp1_valid} !== 2'b00) begin tests_failed++; $display("FAIL reset_rsp_valid got %b%b want 00", rsp0_valid, rsp1_valid); end
    tests_run++;
    if (rsp0_data !== 16'd0 || rsp1_data !== 16'd0) begin tests_failed++; $display("FAIL reset_rsp_data got %0d/%0d want 0/0", rsp0_data, rsp1_data); end
    tests_run++;
    if (mul_in1 !== 16'd0 || mul_in2 !== 16'd0) begin tests_failed++; $display("FAIL reset_mul_in got %0d/%0d want 0/0", mul_in1, mul_in2); end
    rst = 1'b0;
    $display("[TB] test_reset done");
  endtask

  // a=3, b=5 right after reset: accept in cycle 0, result 15 in cycle 3.
  task automatic test_single();
    req0_a = 3; req0_b = 5; rsp0_ready = 1; req0_valid = 1;
    #1;
    tests_run++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin tests_failed++; $display("FAIL single_ready got %b%b want 10", req0_ready, req1_ready); end
    tick(); req0_valid = 0;
    tests_run++;
    if (busy !== 1'b1 || mul_in1 !== 16'd3 || mul_in2 !== 16'd5) begin tests_failed++; $display("FAIL single_launch got busy=%b in=%0d,%0d want busy=1 in=3,5", busy, mul_in1, mul_in2); end
    tick();
    tests_run++;
    if (rsp0_valid !== 1'b0) begin tests_failed++; $display("FAIL single_early_valid got %b want 0", rsp0_valid); end
    tick();
    tests_run++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== 16'd15 || rsp1_valid !== 1'b0) begin tests_failed++; $display("FAIL single_rsp got v0=%b d=%0d v1=%b want v0=1 d=15 v1=0", rsp0_valid, rsp0_data, rsp1_valid); end
    tick();
    tests_run++;
    if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin tests_failed++; $display("FAIL single_idle got busy=%b v0=%b want 0 0", busy, rsp0_valid); end
    rsp0_ready = 0;
    $display("[TB] test_single done");
  endtask

  // Simultaneous requests after reset: req0 (2,7)=14 first, then req1 (4,4)=16.
  task automatic test_both();
    apply_reset();
    req0_a = 2; req0_b = 7; req1_a = 4; req1_b = 4;
    rsp0_ready = 1; rsp1_ready = 1; req0_valid = 1; req1_valid = 1;
    #1;
    tests_run++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin tests_failed++; $display("FAIL both_tie got %b%b want 10", req0_ready, req1_ready); end
    tick(); req0_valid = 0;
    for (int k = 1; k <= 2; k++) begin
      tests_run++;
      if (req1_ready !== 1'b0) begin tests_failed++; $display("FAIL both_hold_c%0d got %b want 0", k, req1_ready); end
      tick();
    end
    tests_run++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== 16'd14 || req1_ready !== 1'b0) begin tests_failed++; $display("FAIL both_rsp0 got v=%b d=%0d r1=%b want 1 14 0", rsp0_valid, rsp0_data, req1_ready); end
    tick();
    tests_run++;
    if (req1_ready !== 1'b1 || rsp1_valid !== 1'b0) begin tests_failed++; $display("FAIL both_grant1 got r1=%b v1=%b want 1 0", req1_ready, rsp1_valid); end
    tick(); req1_valid = 0;
    tick(); tick();
    tests_run++;
    if (rsp1_valid !== 1'b1 || rsp1_data !== 16'd16 || rsp0_valid !== 1'b0) begin tests_failed++; $display("FAIL both_rsp1 got v1=%b d=%0d v0=%b want 1 16 0", rsp1_valid, rsp1_data, rsp0_valid); end
    tick();
    rsp0_ready = 0; rsp1_ready = 0;
    $display("[TB] test_both done");
  endtask

  // Both held valid: grants alternate 0,1,... at one op per 4 cycles.
  task automatic test_round_robin();
    int n;
    int last_acc;
    logic g;
    req0_a = 3; req0_b = 3; req1_a = 5; req1_b = 5;
    rsp0_ready = 1; rsp1_ready = 1; req0_valid = 1; req1_valid = 1;
    last_acc = 0;
    #1;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 8) begin tick(); n++; end
      tests_run++;
      if (n >= 8) begin tests_failed++; $display("FAIL rr_timeout op%0d got no ready want ready", i); end
      g = req1_ready;
      tests_run++;
      if (g !== 1'(i % 2)) begin tests_failed++; $display("FAIL rr_grant op%0d got %b want %0d", i, g, i % 2); end
      if (i > 0) begin
        tests_run++;
        if (cycle_cnt - last_acc != 4) begin tests_failed++; $display("FAIL rr_period op%0d got %0d want 4", i, cycle_cnt - last_acc); end
      end
      last_acc = cycle_cnt;
      tick();
      n = 0;
      while (!(rsp0_valid || rsp1_valid) && n < 8) begin tick(); n++; end
      tests_run++;
      if (i % 2 == 0) begin
        if (rsp0_valid !== 1'b1 || rsp0_data !== 16'd9) begin tests_failed++; $display("FAIL rr_rsp op%0d got v0=%b d=%0d want 1 9", i, rsp0_valid, rsp0_data); end
      end else begin
        if (rsp1_valid !== 1'b1 || rsp1_data !== 16'd25) begin tests_failed++; $display("FAIL rr_rsp op%0d got v1=%b d=%0d want 1 25", i, rsp1_valid, rsp1_data); end
      end
      $display("[TB] rr op%0d grant=%b", i, g);
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    tick();
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  // 300*300 = 90000 wraps to 24464 in 16 bits.
  task automatic test_overflow();
    int n;
    req1_a = 300; req1_b = 300; rsp1_ready = 1; req1_valid = 1;
    #1;
    tests_run++;
    if (req1_ready !== 1'b1) begin tests_failed++; $display("FAIL ovf_ready got %b want 1", req1_ready); end
    tick(); req1_valid = 0;
    n = 0;
    while (!rsp1_valid && n < 8) begin tick(); n++; end
    tests_run++;
    if (rsp1_valid !== 1'b1 || rsp1_data !== 16'd24464) begin tests_failed++; $display("FAIL ovf_data got v=%b d=%0d want 1 24464", rsp1_valid, rsp1_data); end
    tick();
    rsp1_ready = 0;
    $display("[TB] test_overflow done");
  endtask

  // rsp1 held off 5 cycles; output must hold, other traffic ignored.
  task automatic test_backpressure();
    int n;
    req1_a = 6; req1_b = 7; rsp1_ready = 0; req1_valid = 1;
    #1;
    tick(); req1_valid = 0;
    req0_a = 11; req0_b = 12; req0_valid = 1; rsp0_ready = 1;
    n = 0;
    while (!rsp1_valid && n < 8) begin tick(); n++; end
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (rsp1_valid !== 1'b1 || rsp1_data !== 16'd42 || busy !== 1'b1) begin tests_failed++; $display("FAIL bp_hold c%0d got v=%b d=%0d busy=%b want 1 42 1", k, rsp1_valid, rsp1_data, busy); end
      tests_run++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp0_valid !== 1'b0 || mul_in1 !== 16'd6) begin tests_failed++; $display("FAIL bp_quiet c%0d got r=%b%b v0=%b in1=%0d want 00 0 6", k, req0_ready, req1_ready, rsp0_valid, mul_in1); end
      tick();
    end
    req0_valid = 0; rsp1_ready = 1;
    tick();
    tests_run++;
    if (busy !== 1'b0 || rsp1_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_release got busy=%b v1=%b want 0 0", busy, rsp1_valid); end
    rsp0_ready = 0; rsp1_ready = 0;
    $display("[TB] test_backpressure done");
  endtask

  // Reset during WAIT discards the (9,9) op; a later (2,3) op works.
  task automatic test_reset_abort();
    int n;
    int seen;
    req0_a = 9; req0_b = 9; rsp0_ready = 1; req0_valid = 1;
    #1;
    tick(); req0_valid = 0;
    rst = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin tests_failed++; $display("FAIL abort_ctrl got busy=%b v=%b%b want 0 00", busy, rsp0_valid, rsp1_valid); end
    tests_run++;
    if (rsp0_data !== 16'd0 || rsp1_data !== 16'd0 || mul_in1 !== 16'd0 || mul_in2 !== 16'd0) begin tests_failed++; $display("FAIL abort_data got d=%0d/%0d in=%0d/%0d want 0", rsp0_data, rsp1_data, mul_in1, mul_in2); end
    tick();
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (rsp0_valid) seen++;
      tick();
    end
    tests_run++;
    if (seen != 0) begin tests_failed++; $display("FAIL abort_ghost got %0d valid cycles want 0", seen); end
    req0_a = 2; req0_b = 3; req0_valid = 1;
    #1;
    tests_run++;
    if (req0_ready !== 1'b1) begin tests_failed++; $display("FAIL abort_next_ready got %b want 1", req0_ready); end
    tick(); req0_valid = 0;
    n = 0;
    while (!rsp0_valid && n < 8) begin tick(); n++; end
    tests_run++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== 16'd6) begin tests_failed++; $display("FAIL abort_next_rsp got v=%b d=%0d want 1 6", rsp0_valid, rsp0_data); end
    tick();
    rsp0_ready = 0;
    $display("[TB] test_reset_abort done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_both();
    test_round_robin();
    test_overflow();
    test_backpressure();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
